uart_echo_fifo: RTL

Parametrised UART echo engine between the `uart_basic` receive and transmit sides, replacing direct wiring of `rx_data`/`rx_ready` to `tx_data`/`tx_start`. Received bytes go into a FIFO, so back-to-back bytes arriving while the transmitter is busy are kept rather than lost. A run-time mode selects plain echo, uppercase echo, or line-buffered echo. The block also reports FIFO occupancy and a sticky overflow flag.

---
 rtl/uart_echo_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_echo_fifo.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo engine.
// Optional statistics counters are enabled by defining UART_ECHO_STATS_EN.
package uart_echo_pkg;

  // Run-time echo behaviour; encoding 2'd3 is decoded as ECHO by the top.
  typedef enum logic [1:0] {
    ECHO  = 2'd0,
    UPPER = 2'd1,
    LINE  = 2'd2
  } echo_mode_t;

  // Transmit handshake sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_t;

  localparam logic [7:0] UPPER_LO = 8'h61;
  localparam logic [7:0] UPPER_HI = 8'h7A;
  localparam logic [7:0] CASE_OFS = 8'h20;

  localparam int STAT_W = 16;

  // ASCII lowercase letters map to uppercase; every other byte is untouched.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= UPPER_LO && b <= UPPER_HI) begin
      return b - CASE_OFS;
    end
    return b;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    if (v == {STAT_W{1'b1}}) begin
      return v;
    end
    return v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: dout presents the oldest entry while not empty.
// Depth must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk_100M,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // Qualify requests so a misuse from outside can never corrupt occupancy.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  // NOTE: the array has no reset; emptiness is tracked by count_q, so stale
  // data is never observable and the RAM can map to plain storage cells.
  always_ff @(posedge clk_100M) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART echo engine: buffers received bytes and replays them to the
// transmitter in plain, uppercase or line-buffered mode.
// Define UART_ECHO_STATS_EN to build the rx/tx/drop statistics counters;
// otherwise those ports are tied to zero.
module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] TERMINATOR = 8'h0D,
  localparam int        CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_100M,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  input  logic                  tx_busy,
  input  logic [1:0]            mode,
  input  logic                  clear,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [CW-1:0]         fifo_count,
  output logic                  overflow,
  output logic [STAT_W-1:0]     rx_count,
  output logic [STAT_W-1:0]     tx_count,
  output logic [STAT_W-1:0]     drop_count
);

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  push;
  logic                  pop;
  logic                  drop;
  echo_mode_t            cur_mode;
  logic                  send_ok;

  tx_state_t             state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CW-1:0]         line_cnt_q, line_cnt_d;
  logic                  overflow_q, overflow_d;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_100M (clk_100M),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .din      (rx_data),
    .dout     (fifo_dout),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Decode the mode input; the reserved encoding behaves as plain echo.
  always_comb begin
    cur_mode = ECHO;
    if (mode == UPPER) begin
      cur_mode = UPPER;
    end else if (mode == LINE) begin
      cur_mode = LINE;
    end
  end

  // Line mode holds bytes until a full line is queued, or the FIFO fills up
  // and would otherwise deadlock.
  always_comb begin
    send_ok = 1'b1;
    if (cur_mode == LINE) begin
      send_ok = (line_cnt_q != '0) || fifo_full;
    end
  end

  // Transmit sequencer. Mode is consumed only at the pop in IDLE, where the
  // transform is folded into tx_data, so a mid-transfer change waits for the
  // next byte without needing a separate mode register.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && send_ok) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = fifo_dout;
          if (cur_mode == UPPER) begin
            tx_data_d[7:0] = to_upper(fifo_dout[7:0]);
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Accept a byte when there is room now or a slot frees up this cycle.
  always_comb begin
    push = rx_ready && (!fifo_full || pop);
    drop = rx_ready && !push;
  end

  // Count complete lines queued; simultaneous terminator push/pop cancels.
  always_comb begin
    line_cnt_d = line_cnt_q;
    unique case ({push && (rx_data[7:0] == TERMINATOR),
                  pop && (fifo_dout[7:0] == TERMINATOR)})
      2'b10:   line_cnt_d = line_cnt_q + CW'(1);
      2'b01:   line_cnt_d = line_cnt_q - CW'(1);
      default: line_cnt_d = line_cnt_q;
    endcase
  end

  // Sticky overflow: a drop wins over a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear) begin
      overflow_d = 1'b0;
    end
  end

  // Control-path state registers.
  // NOTE: all state uses non-blocking assignment so every flop samples the
  // pre-edge values computed by the combinational blocks above.
  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      line_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      line_cnt_q <= line_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

`ifdef UART_ECHO_STATS_EN
  logic [STAT_W-1:0] rx_count_q, rx_count_d;
  logic [STAT_W-1:0] tx_count_q, tx_count_d;
  logic [STAT_W-1:0] drop_count_q, drop_count_d;

  // Saturating statistics; clear takes priority over a same-cycle event.
  always_comb begin
    rx_count_d   = rx_count_q;
    tx_count_d   = tx_count_q;
    drop_count_d = drop_count_q;
    if (clear) begin
      rx_count_d   = '0;
      tx_count_d   = '0;
      drop_count_d = '0;
    end else begin
      if (push)       rx_count_d   = sat_inc(rx_count_q);
      if (tx_start_q) tx_count_d   = sat_inc(tx_count_q);
      if (drop)       drop_count_d = sat_inc(drop_count_q);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      rx_count_q   <= '0;
      tx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      rx_count_q   <= rx_count_d;
      tx_count_q   <= tx_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign rx_count   = rx_count_q;
  assign tx_count   = tx_count_q;
  assign drop_count = drop_count_q;
`else
  assign rx_count   = '0;
  assign tx_count   = '0;
  assign drop_count = '0;
`endif

endmodule
